// File: rtl/rr_port_mux.sv
// N-port round-robin merge onto a single registered valid/ready output stage,
// tagging each word with its source port and counting accepted words per port.
module rr_port_mux #(
    parameter int  NUM_PORTS  = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  CNT_WIDTH  = 16,
    localparam int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [PW-1:0]                   out_port,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  xfer_count
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [PW-1:0]         out_port_q,  out_port_d;
    logic [PW-1:0]         ptr_q,       ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_PORTS];

    logic                  load_en_s;
    logic                  grant_any_s;
    logic [NUM_PORTS-1:0]  grant_s;
    logic [PW-1:0]         grant_idx_s;
    logic [PW-1:0]         idx_v;
    logic [DATA_WIDTH-1:0] sel_data_s;

    // Arbiter: first valid port at or after ptr, only when the output can load
    always_comb begin
        load_en_s   = !out_valid_q || out_ready;
        grant_any_s = 1'b0;
        grant_s     = '0;
        grant_idx_s = '0;
        sel_data_s  = '0;
        idx_v       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx_v = PW'((int'(ptr_q) + k) % NUM_PORTS);
            if (load_en_s && !grant_any_s && in_valid[idx_v]) begin
                grant_any_s     = 1'b1;
                grant_s[idx_v]  = 1'b1;
                grant_idx_s     = idx_v;
                sel_data_s      = in_data[int'(idx_v)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    assign in_ready = grant_s;

    // Next-state: a grant loads (and may simultaneously replace a draining word)
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        ptr_d       = ptr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (grant_any_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_port_d  = grant_idx_s;
            if (int'(grant_idx_s) == NUM_PORTS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_s + PW'(1);
            end
            if (cnt_q[grant_idx_s] != {CNT_WIDTH{1'b1}}) begin
                cnt_d[grant_idx_s] = cnt_q[grant_idx_s] + CNT_WIDTH'(1);
            end else begin
                cnt_d[grant_idx_s] = cnt_q[grant_idx_s];
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            ptr_q       <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            ptr_q       <= ptr_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flatten counters into the same slicing as in_data
    always_comb begin
        xfer_count = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            xfer_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;

endmodule

// File: tb/tb_rr_port_mux.sv
// Directed testbench for rr_port_mux: a 4-port/16-bit-counter instance for the
// arbitration scenarios and a 4-port/4-bit-counter instance for saturation.
module tb_rr_port_mux;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_port;
    logic [63:0] xfer_count;

    logic [3:0]  s_in_valid;
    logic [3:0]  s_in_ready;
    logic [31:0] s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic [1:0]  s_out_port;
    logic [15:0] s_xfer_count;

    int n_vec;
    int n_err;
    logic [15:0] exp_cnt [4];

    rr_port_mux #(.NUM_PORTS(4), .DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_port(out_port), .xfer_count(xfer_count)
    );

    rr_port_mux #(.NUM_PORTS(4), .DATA_WIDTH(8), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_port(s_out_port), .xfer_count(s_xfer_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 4'h0; in_data = 32'h0; out_ready = 1'b0;
        s_in_valid = 4'h0; s_in_data = 32'h0; s_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) exp_cnt[j] = 16'd0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 4'h0 || xfer_count !== 64'h0 ||
                out_data !== 8'h00 || out_port !== 2'd0) begin
                n_err++;
                $display("FAIL reset c%0d: valid=%b ready=%b cnt=%h data=%h port=%0d, want 0,0,0,0,0",
                         c, out_valid, in_ready, xfer_count, out_data, out_port);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] ep;
        logic [7:0] ed;
        logic [3:0] er;
        in_data = {8'h40, 8'h30, 8'h20, 8'h10};
        in_valid = 4'hF;
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL rr_first_ready: got %b want 0001", in_ready);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            ep = 2'(c % 4);
            ed = 8'((c % 4 + 1) * 16);
            er = 4'b0001 << ((c + 1) % 4);
            exp_cnt[ep] = exp_cnt[ep] + 16'd1;
            n_vec++;
            if (out_valid !== 1'b1 || out_port !== ep || out_data !== ed || in_ready !== er) begin
                n_err++;
                $display("FAIL rr c%0d: valid=%b port=%0d data=%h ready=%b, want 1 %0d %h %b",
                         c, out_valid, out_port, out_data, in_ready, ep, ed, er);
            end
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (xfer_count[j*16 +: 16] !== exp_cnt[j]) begin
                    n_err++;
                    $display("FAIL rr_cnt c%0d p%0d: got %0d want %0d", c, j, xfer_count[j*16 +: 16], exp_cnt[j]);
                end
            end
        end
        in_valid = 4'h0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h40 || out_port !== 2'd3) begin
            n_err++;
            $display("FAIL rr_drain: valid=%b data=%h port=%0d, want 0 40 3", out_valid, out_data, out_port);
        end
    endtask

    task automatic test_single_port();
        in_data = {8'h40, 8'hA5, 8'h20, 8'h10};
        in_valid = 4'b0100;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_cnt[2] = exp_cnt[2] + 16'd1;
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_port !== 2'd2) begin
                n_err++;
                $display("FAIL single c%0d: valid=%b data=%h port=%0d, want 1 a5 2", c, out_valid, out_data, out_port);
            end
        end
        n_vec++;
        if (xfer_count[2*16 +: 16] !== exp_cnt[2]) begin
            n_err++;
            $display("FAIL single_cnt: got %0d want %0d", xfer_count[2*16 +: 16], exp_cnt[2]);
        end
        // ptr now 3: port 3 wins over 0 and 1
        in_valid = 4'b1011;
        #1;
        n_vec++;
        if (in_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL ptr_is_3: ready=%b want 1000", in_ready);
        end
        in_valid = 4'b0010;
        #1;
        n_vec++;
        if (in_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL wrap_ready: ready=%b want 0010", in_ready);
        end
        tick();
        exp_cnt[1] = exp_cnt[1] + 16'd1;
        n_vec++;
        if (out_valid !== 1'b1 || out_port !== 2'd1 || out_data !== 8'hA5 - 8'h85 || xfer_count[16 +: 16] !== exp_cnt[1]) begin
            n_err++;
            $display("FAIL wrap_load: valid=%b port=%0d data=%h cnt1=%0d, want 1 1 20 %0d",
                     out_valid, out_port, out_data, xfer_count[16 +: 16], exp_cnt[1]);
        end
        in_valid = 4'h0;
        tick();
    endtask

    task automatic test_stall();
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid = 4'b0001;
        out_ready = 1'b0;
        tick();
        exp_cnt[0] = exp_cnt[0] + 16'd1;
        in_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 8'h11 || out_port !== 2'd0 || in_ready !== 4'h0) begin
                n_err++;
                $display("FAIL stall c%0d: valid=%b data=%h port=%0d ready=%b, want 1 11 0 0000",
                         c, out_valid, out_data, out_port, in_ready);
            end
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            n_vec++;
            if (xfer_count[j*16 +: 16] !== exp_cnt[j]) begin
                n_err++;
                $display("FAIL stall_cnt p%0d: got %0d want %0d", j, xfer_count[j*16 +: 16], exp_cnt[j]);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL release_ready: ready=%b want 0010", in_ready);
        end
        tick();
        exp_cnt[1] = exp_cnt[1] + 16'd1;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h22 || out_port !== 2'd1 || xfer_count[16 +: 16] !== exp_cnt[1]) begin
            n_err++;
            $display("FAIL drain_load: valid=%b data=%h port=%0d cnt1=%0d, want 1 22 1 %0d",
                     out_valid, out_data, out_port, xfer_count[16 +: 16], exp_cnt[1]);
        end
        in_valid = 4'h0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h22) begin
            n_err++;
            $display("FAIL stall_drain: valid=%b data=%h, want 0 22", out_valid, out_data);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] ec;
        s_in_data = {8'h00, 8'h00, 8'h00, 8'h5C};
        s_in_valid = 4'b0001;
        s_out_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            ec = (k > 15) ? 4'd15 : 4'(k);
            n_vec++;
            if (s_xfer_count !== {12'h000, ec} || s_out_data !== 8'h5C || s_out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL sat k%0d: cnt=%h data=%h valid=%b, want %h 5c 1",
                         k, s_xfer_count, s_out_data, s_out_valid, {12'h000, ec});
            end
        end
        s_in_valid = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid();
        in_data = {8'h00, 8'h55, 8'h00, 8'h00};
        in_valid = 4'b0100;
        out_ready = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h55) begin
            n_err++;
            $display("FAIL pre_reset: valid=%b data=%h, want 1 55", out_valid, out_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_data = {8'h04, 8'h03, 8'h02, 8'h01};
        in_valid = 4'hF;
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_port !== 2'd0 ||
            xfer_count !== 64'h0 || s_xfer_count !== 16'h0 || in_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_mid: valid=%b data=%h port=%0d cnt=%h scnt=%h ready=%b, want 0 00 0 0 0 0001",
                     out_valid, out_data, out_port, xfer_count, s_xfer_count, in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_port !== 2'd0 || out_data !== 8'h01 || xfer_count !== 64'h1) begin
            n_err++;
            $display("FAIL restart: valid=%b port=%0d data=%h cnt=%h, want 1 0 01 1",
                     out_valid, out_port, out_data, xfer_count);
        end
        in_valid = 4'h0;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_round_robin();
        test_single_port();
        test_stall();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_port_mux.md
# rr_port_mux

Parametrised N-port round-robin multiplexer with a registered valid/ready output stage and per-port transfer counters. It is the generalised successor of fixed-port leaf modules: any number of identical input channels, each with its own handshake, merge fairly onto one output stream. It sits between several producer instances and one consumer, and identifies which port each output word came from.

## Interface
- `NUM_PORTS`, default 4: number of input channels; must be ≥1.
- `DATA_WIDTH`, default 8: payload width per channel.
- `CNT_WIDTH`, default 16: width of each per-port saturating transfer counter.
- `PW`, derived as max(1, $clog2(NUM_PORTS)): port-index width.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input NUM_PORTS: per-port valid, bit i = port i.
- `in_ready` output NUM_PORTS: per-port ready, combinational.
- `in_data` input NUM_PORTS*DATA_WIDTH: port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `out_valid` output 1: output register holds a word.
- `out_ready` input 1: consumer accepts.
- `out_data` output DATA_WIDTH: held payload.
- `out_port` output PW: source port of the held payload.
- `xfer_count` output NUM_PORTS*CNT_WIDTH: accepted-word count per port, in the same slicing as `in_data`.

## Operation
- Output stage: one-entry register holding `out_valid`, `out_data` and `out_port`.
- `load_en` = !out_valid || out_ready.
- Arbiter: when `load_en` is high, grant the first port with `in_valid` set, searching ptr, ptr+1, … modulo NUM_PORTS.
- `in_ready[i]` = load_en && grant[i]. At most one bit is high. It may depend combinationally on `in_valid` and `out_ready`.
- Input transfer on port i: in_valid[i] && in_ready[i]. On transfer:
  - out_data ← slice i;
  - out_port ← i;
  - out_valid ← 1;
  - ptr ← (i+1) mod NUM_PORTS;
  - xfer_count[i] += 1, saturating at all-ones (it holds at 2^CNT_WIDTH−1).
- Output drained with no new transfer (out_valid && out_ready, no grant): out_valid ← 0. out_data and out_port keep their last values.
- No valid inputs: no grant, and ptr is unchanged.
- Stall: while out_valid && !out_ready, out_data and out_port are stable and every in_ready is 0.
- NUM_PORTS=1: ptr is constant 0 and out_port is constant 0.

## Timing
- Reset values: out_valid=0, out_data=0, out_port=0, ptr=0, all xfer_count=0, in_ready=0 (out_valid is 0 but no in_valid is asserted).
- Reset dominates all other activity in the same cycle. Reset mid-operation drops the held word and leaves no output transfer pending.
- Latency: an input accepted at edge k appears on out_valid/out_data after edge k (one cycle).
- Throughput: one word per cycle while out_ready=1 and any input is valid. A simultaneous drain and load in the same cycle is required.
- Counters update on the same edge as the accepting transfer.

## Test plan
- Reset, then all in_valid=0 for 5 cycles:
  - out_valid=0, in_ready=0, all counters 0.
- NUM_PORTS=4, all ports valid continuously with data 0x10,0x20,0x30,0x40, out_ready=1:
  - out_port sequence 0,1,2,3,0,… and out_data 0x10,0x20,0x30,0x40,…, one word per cycle;
  - each counter rises by 1 every 4 cycles.
- Only port 2 valid (data 0xA5), out_ready=1 for 3 cycles:
  - three outputs 0xA5 with out_port=2;
  - ptr=3 afterwards;
  - then port 1 alone is granted next (wrap 3→0→1).
- Hold out_ready=0 after port 0 loads 0x11:
  - out_data stays 0x11 and all in_ready stay 0 for 10 cycles;
  - raising out_ready drains 0x11 and loads the next granted word in the same cycle.
- CNT_WIDTH=4, port 0 sends 20 words:
  - xfer_count[0] reaches 15 and holds there.
- Assert rst while out_valid=1 and holding 0x55:
  - next cycle out_valid=0, out_data=0, counters 0;
  - the arbiter restarts at port 0.
